skip_fetch_pipe: RTL
====================

Name: skip_fetch_pipe

Overview:
- Parametrised, pipelined successor of the fetch-stage skip-table lookup.
- A predicted PC enters through a valid/ready request port and is compared against a CAM of skip-entry PCs.
- Eligibility is checked against pointer-register SIM bits, reuse-buffer validity, per-slot skip history and a per-entry confidence counter.
- Returns the next fetch PC plus reuse-buffer read enables on a valid/ready response port, two cycles after acceptance. Sits between the branch predictor and the I-cache request stage.

Parameters:
- ENTRIES, 16: skip-table depth (power of 2, ≥2).
- PC_WIDTH, 32: PC width.
- RB_ENTRIES, 16: reuse-buffer slots (≤16; 4-bit index fields).
- NUM_PTR_REGS, 32: pointer registers with SIM bit (≤32; 5-bit field).
- CONF_WIDTH, 2: confidence counter width.
- CONF_THRESHOLD, 2: minimum confidence for a skip.
- SKIP_SHIFT, 2: left shift applied to SkipCount to form the byte offset.

Ports:
- ClockIn  in  1  clock, rising edge.
- AsyncResetIn  in  1  asynchronous, active-high reset.
- ReqValidIn  in  1  request valid.
- ReqReadyOut  out  1  request ready.
- ReqPCIn  in  PC_WIDTH  predicted PC.
- RspValidOut  out  1  response valid.
- RspReadyIn  in  1  response ready.
- RspNextPCOut  out  PC_WIDTH  next fetch PC.
- RspSkipEnOut  out  1  skip taken.
- RspHitOut  out  1  CAM hit.
- RspIdxOut  out  clog2(ENTRIES)  hit entry index.
- RspRs1ReadEnOut / RspRs2ReadEnOut  out  1  reuse-buffer read enables.
- RspRdIdxOut  out  4  destination reuse-buffer slot.
- FlushIn  in  1  kill all in-flight lookups.
- CfgWrEnIn  in  1  table write.
- CfgWrAddrIn  in  clog2(ENTRIES)+1  [0]=0 PC word, [0]=1 entry word; upper bits = index.
- CfgWrDataIn  in  32  write data.
- PtrSimVecIn  in  NUM_PTR_REGS  pointer SIM bits.
- RBValidIn  in  RB_ENTRIES  reuse-buffer slot valid.
- SkipFailIn  in  1  commit reports a wrong skip.
- SkipFailIdxIn  in  clog2(ENTRIES)  entry index of the wrong skip.

Behaviour:
- Reset (asynchronous, AsyncResetIn=1) clears:
  - all CAM PCs, entries, confidence counters, the slot-skipped vector and both stage valids;
  - all outputs to 0, including ReqReadyOut.
- After reset deasserts, ReqReadyOut = !S1v | S1 advancing.
- Entry word layout:
  - [31] valid, [30] type (0 load, 1 compute), [29:25] ptrReg, [24] rs2Ignore;
  - [23:20] rs1Slot, [19:16] rs2Slot, [15:12] rdSlot, [7:0] SkipCount.
- Config write is synchronous.
  - An entry-word write sets that entry's confidence to all-ones.
  - A PC-word write leaves confidence unchanged.
- Stage S1: on request handshake, registers the PC and the hit vector (CamPC[i]==ReqPCIn && valid[i]). Multiple hits: lowest index wins.
- S1 advances into S2 when !S2v | RspReadyIn. Entry fields, confidence and the slot vector are sampled at that edge; a same-cycle config write is not seen.
- Skip decision (evaluated at S1→S2) requires all of:
  - a hit;
  - conf ≥ CONF_THRESHOLD;
  - load entries: PtrSimVecIn[ptrReg]=1;
  - compute entries: Skipped[rs1Slot] & RBValidIn[rs1Slot], and additionally (rs2Ignore | (Skipped[rs2Slot] & RBValidIn[rs2Slot])).
- Response fields:
  - NextPC = PC + (SkipCount << SKIP_SHIFT) modulo 2^PC_WIDTH when skipping, else PC.
  - Rs1ReadEn = skipEn.
  - Rs2ReadEn = skipEn & type & !rs2Ignore.
- On hit at the S1→S2 transfer, Skipped[rdSlot] <= skipEn.
- Latency: request accepted at edge N gives RspValidOut at N+2. Full throughput of one per cycle while RspReadyIn=1.
- Response fields are held stable while RspValidOut & !RspReadyIn.
- Confidence updates:
  - +1, saturating, on response handshake with RspSkipEnOut=1.
  - SkipFailIn: −1, saturating at 0.
  - Priority when events coincide on one index: config write > fail > increment.
- FlushIn clears S1v/S2v at the next edge, accepts no request that cycle and performs no slot-vector update. Config writes still apply.
- Reset mid-operation discards all state immediately.

Test Plan:
1. Write PC 0x100 and entry {valid, load, ptr 3, SkipCount 5} at index 2; PtrSimVecIn[3]=1; request 0x100 → two cycles later RspHit=1, Idx=2, SkipEn=1, NextPC=0x114, Rs1ReadEn=1, Rs2ReadEn=0.
2. Same entry at indices 1 and 4, request its PC → Idx=1. Miss at 0x200 → NextPC=0x200, SkipEn=0.
3. Compute entry, rs1Slot 3 / rs2Slot 5, with producers skipped earlier into slots 3 and 5, RBValid[3]=RBValid[5]=1 → SkipEn=1, both ReadEns=1. Clear RBValid[5] → SkipEn=0, Skipped[rdSlot] cleared.
4. Pulse SkipFailIn idx 2 twice from conf 3 → conf 1, next lookup SkipEn=0. A same-cycle fail and skip handshake on idx 2 → net decrement.
5. Hold RspReadyIn=0 for 3 cycles with back-to-back requests → ReqReadyOut drops after 2 accepted, outputs stable, no loss or duplication.
6. FlushIn with both stages full → no RspValidOut next cycle, slot vector unchanged. Assert AsyncResetIn mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/skip_fetch_pipe.sv
// Two-stage skip-table lookup between the branch predictor and I-cache request stage.
// A predicted PC is matched against the CAM, and eligible hits return a PC advanced past skippable code.
module skip_fetch_pipe #(
  parameter int unsigned ENTRIES        = 16,
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned RB_ENTRIES     = 16,
  parameter int unsigned NUM_PTR_REGS   = 32,
  parameter int unsigned CONF_WIDTH     = 2,
  parameter int unsigned CONF_THRESHOLD = 2,
  parameter int unsigned SKIP_SHIFT     = 2
) (
  input  logic                        ClockIn,
  input  logic                        AsyncResetIn,
  input  logic                        ReqValidIn,
  output logic                        ReqReadyOut,
  input  logic [PC_WIDTH-1:0]         ReqPCIn,
  output logic                        RspValidOut,
  input  logic                        RspReadyIn,
  output logic [PC_WIDTH-1:0]         RspNextPCOut,
  output logic                        RspSkipEnOut,
  output logic                        RspHitOut,
  output logic [$clog2(ENTRIES)-1:0]  RspIdxOut,
  output logic                        RspRs1ReadEnOut,
  output logic                        RspRs2ReadEnOut,
  output logic [3:0]                  RspRdIdxOut,
  input  logic                        FlushIn,
  input  logic                        CfgWrEnIn,
  input  logic [$clog2(ENTRIES):0]    CfgWrAddrIn,
  input  logic [31:0]                 CfgWrDataIn,
  input  logic [NUM_PTR_REGS-1:0]     PtrSimVecIn,
  input  logic [RB_ENTRIES-1:0]       RBValidIn,
  input  logic                        SkipFailIn,
  input  logic [$clog2(ENTRIES)-1:0]  SkipFailIdxIn
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CONF_WIDTH-1:0] CONF_MAX = '1;
  localparam logic [CONF_WIDTH-1:0] CONF_THR = CONF_WIDTH'(CONF_THRESHOLD);

  logic [PC_WIDTH-1:0]   cam_pc_q [ENTRIES];
  logic [PC_WIDTH-1:0]   cam_pc_d [ENTRIES];
  logic [31:0]           entry_q  [ENTRIES];
  logic [31:0]           entry_d  [ENTRIES];
  logic [CONF_WIDTH-1:0] conf_q   [ENTRIES];
  logic [CONF_WIDTH-1:0] conf_d   [ENTRIES];
  logic [15:0]           skipped_q, skipped_d;

  logic                  s1_v_q, s1_v_d;
  logic [PC_WIDTH-1:0]   s1_pc_q, s1_pc_d;
  logic [ENTRIES-1:0]    s1_hit_q, s1_hit_d;

  logic                  s2_v_q, s2_v_d;
  logic [PC_WIDTH-1:0]   rsp_pc_q, rsp_pc_d;
  logic                  rsp_skip_q, rsp_skip_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic [IDX_W-1:0]      rsp_idx_q, rsp_idx_d;
  logic                  rsp_rs1_q, rsp_rs1_d;
  logic                  rsp_rs2_q, rsp_rs2_d;
  logic [3:0]            rsp_rd_q, rsp_rd_d;

  logic                  s1_adv;
  logic                  req_fire;
  logic                  rsp_fire;
  logic [ENTRIES-1:0]    req_hit;
  logic                  sel_hit;
  logic [IDX_W-1:0]      sel_idx;
  logic [31:0]           sel_entry;
  logic                  sel_type;
  logic [4:0]            sel_ptr;
  logic                  sel_rs2_ign;
  logic [3:0]            sel_rs1, sel_rs2, sel_rd;
  logic [7:0]            sel_cnt;
  logic [15:0]           rb_vec;
  logic [31:0]           ptr_vec;
  logic                  eligible;
  logic                  skip_en;
  logic [PC_WIDTH-1:0]   next_pc;
  logic [IDX_W-1:0]      cfg_idx;
  logic                  unused_bits;

  assign s1_adv      = s1_v_q & (~s2_v_q | RspReadyIn);
  assign ReqReadyOut = ~AsyncResetIn & ~FlushIn & (~s1_v_q | s1_adv);
  assign req_fire    = ReqValidIn & ReqReadyOut;
  assign rsp_fire    = s2_v_q & RspReadyIn;
  assign cfg_idx     = CfgWrAddrIn[IDX_W:1];
  assign rb_vec      = 16'(RBValidIn);
  assign ptr_vec     = 32'(PtrSimVecIn);

  assign RspValidOut     = s2_v_q;
  assign RspNextPCOut    = rsp_pc_q;
  assign RspSkipEnOut    = rsp_skip_q;
  assign RspHitOut       = rsp_hit_q;
  assign RspIdxOut       = rsp_idx_q;
  assign RspRs1ReadEnOut = rsp_rs1_q;
  assign RspRs2ReadEnOut = rsp_rs2_q;
  assign RspRdIdxOut     = rsp_rd_q;

  // CAM match of the incoming request against valid entries
  always_comb begin
    req_hit = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      req_hit[i] = entry_q[i][31] && (cam_pc_q[i] == ReqPCIn);
    end
  end

  // Lowest-index hit selection and skip eligibility for the S1 -> S2 transfer
  always_comb begin
    sel_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (s1_hit_q[i]) sel_idx = IDX_W'(i);
    end
    sel_hit     = |s1_hit_q;
    sel_entry   = entry_q[sel_idx];
    sel_type    = sel_entry[30];
    sel_ptr     = sel_entry[29:25];
    sel_rs2_ign = sel_entry[24];
    sel_rs1     = sel_entry[23:20];
    sel_rs2     = sel_entry[19:16];
    sel_rd      = sel_entry[15:12];
    sel_cnt     = sel_entry[7:0];
    if (sel_type) begin
      eligible = skipped_q[sel_rs1] & rb_vec[sel_rs1] &
                 (sel_rs2_ign | (skipped_q[sel_rs2] & rb_vec[sel_rs2]));
    end else begin
      eligible = ptr_vec[sel_ptr];
    end
    skip_en = sel_hit & (conf_q[sel_idx] >= CONF_THR) & eligible;
    next_pc = skip_en ? (s1_pc_q + (PC_WIDTH'(sel_cnt) << SKIP_SHIFT)) : s1_pc_q;
  end

  assign unused_bits = ^{sel_entry[31], sel_entry[11:8]};

  always_comb begin
    cam_pc_d   = cam_pc_q;
    entry_d    = entry_q;
    conf_d     = conf_q;
    skipped_d  = skipped_q;
    s1_v_d     = s1_v_q;
    s1_pc_d    = s1_pc_q;
    s1_hit_d   = s1_hit_q;
    s2_v_d     = s2_v_q;
    rsp_pc_d   = rsp_pc_q;
    rsp_skip_d = rsp_skip_q;
    rsp_hit_d  = rsp_hit_q;
    rsp_idx_d  = rsp_idx_q;
    rsp_rs1_d  = rsp_rs1_q;
    rsp_rs2_d  = rsp_rs2_q;
    rsp_rd_d   = rsp_rd_q;

    if (FlushIn) begin
      s1_v_d = 1'b0;
    end else if (req_fire) begin
      s1_v_d   = 1'b1;
      s1_pc_d  = ReqPCIn;
      s1_hit_d = req_hit;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end

    // Response register loads only on a live transfer; flush kills it and its slot update
    if (FlushIn) begin
      s2_v_d = 1'b0;
    end else if (s1_adv) begin
      s2_v_d     = 1'b1;
      rsp_pc_d   = next_pc;
      rsp_skip_d = skip_en;
      rsp_hit_d  = sel_hit;
      rsp_idx_d  = sel_hit ? sel_idx : '0;
      rsp_rs1_d  = skip_en;
      rsp_rs2_d  = skip_en & sel_type & ~sel_rs2_ign;
      rsp_rd_d   = sel_hit ? sel_rd : 4'h0;
      if (sel_hit) skipped_d[sel_rd] = skip_en;
    end else if (rsp_fire) begin
      s2_v_d = 1'b0;
    end

    if (CfgWrEnIn) begin
      if (CfgWrAddrIn[0]) entry_d[cfg_idx]  = CfgWrDataIn;
      else                cam_pc_d[cfg_idx] = PC_WIDTH'(CfgWrDataIn);
    end

    // Confidence: config write beats a reported failure, which beats a successful skip
    for (int i = 0; i < ENTRIES; i++) begin
      if (CfgWrEnIn && CfgWrAddrIn[0] && (cfg_idx == IDX_W'(i))) begin
        conf_d[i] = CONF_MAX;
      end else if (SkipFailIn && (SkipFailIdxIn == IDX_W'(i))) begin
        if (conf_q[i] != '0) conf_d[i] = conf_q[i] - CONF_WIDTH'(1);
      end else if (rsp_fire && rsp_skip_q && (rsp_idx_q == IDX_W'(i))) begin
        if (conf_q[i] != CONF_MAX) conf_d[i] = conf_q[i] + CONF_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge ClockIn or posedge AsyncResetIn) begin
    if (AsyncResetIn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cam_pc_q[i] <= '0;
        entry_q[i]  <= '0;
        conf_q[i]   <= '0;
      end
      skipped_q  <= '0;
      s1_v_q     <= 1'b0;
      s1_pc_q    <= '0;
      s1_hit_q   <= '0;
      s2_v_q     <= 1'b0;
      rsp_pc_q   <= '0;
      rsp_skip_q <= 1'b0;
      rsp_hit_q  <= 1'b0;
      rsp_idx_q  <= '0;
      rsp_rs1_q  <= 1'b0;
      rsp_rs2_q  <= 1'b0;
      rsp_rd_q   <= '0;
    end else begin
      cam_pc_q   <= cam_pc_d;
      entry_q    <= entry_d;
      conf_q     <= conf_d;
      skipped_q  <= skipped_d;
      s1_v_q     <= s1_v_d;
      s1_pc_q    <= s1_pc_d;
      s1_hit_q   <= s1_hit_d;
      s2_v_q     <= s2_v_d;
      rsp_pc_q   <= rsp_pc_d;
      rsp_skip_q <= rsp_skip_d;
      rsp_hit_q  <= rsp_hit_d;
      rsp_idx_q  <= rsp_idx_d;
      rsp_rs1_q  <= rsp_rs1_d;
      rsp_rs2_q  <= rsp_rs2_d;
      rsp_rd_q   <= rsp_rd_d;
    end
  end

endmodule
